rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Width, default 32, ROM word width in bits.
REQ-002 Depth, default 32, number of ROM words.
REQ-003 AddrWidth, localparam $clog2(Depth), requester and ROM address width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  [1:0]  per-port read request.
REQ-007 req_addr  input  [1:0][AddrWidth-1:0]  per-port word address.
REQ-008 req_ready  output  [1:0]  per-port request accepted this cycle.
REQ-009 resp_valid  output  [1:0]  per-port response available.
REQ-010 resp_data  output  [1:0][Width-1:0]  per-port read data.
REQ-011 resp_err  output  [1:0]  per-port flag: address was >= Depth.
REQ-012 resp_ready  input  [1:0]  per-port response consumed.
REQ-013 rom_addr  output  [AddrWidth-1:0]  address to the shared synchronous ROM, which has 1-cycle registered read latency.
REQ-014 rom_data  input  [Width-1:0]  ROM read data, valid one cycle after rom_addr is presented.

Function
REQ-015 The block SHALL share one ROM read port between two requesters, granting at most one request per cycle.
REQ-016 A request SHALL be accepted (valid and ready both high in the same cycle) only when the port is eligible: count_i + inflight_i - pop_i < 2, where count_i is the port's response FIFO occupancy, inflight_i is 1 if the port was granted last cycle, and pop_i = resp_valid_i & resp_ready_i.
REQ-017 req_ready SHALL be combinational from req_valid, eligibility and the round-robin pointer; req_ready[i] SHALL never be high when req_valid[i] is low.
REQ-018 Arbitration SHALL be round-robin: when both ports are valid and eligible, the port not granted most recently wins; the pointer SHALL update only on a grant.
REQ-019 If only one port is valid and eligible, it SHALL be granted regardless of the pointer.
REQ-020 rom_addr SHALL equal the granted port's req_addr in the grant cycle, and 0 when there is no grant.
REQ-021 One cycle after a grant, {err, rom_data} SHALL be written into the granted port's 2-entry response FIFO; err SHALL be 1 if the granted address was >= Depth (data is then 0, as returned by the ROM).
REQ-022 Latency SHALL be 1 cycle: a grant at edge N yields resp_valid high after edge N+1, provided the FIFO was empty.
REQ-023 resp_valid, resp_data and resp_err SHALL present the FIFO head and be held stable while resp_valid=1 and resp_ready=0.
REQ-024 A simultaneous FIFO push and pop SHALL leave the count unchanged and preserve order; a push into a full FIFO SHALL be impossible by construction (REQ-016).
REQ-025 With resp_ready held high, each port SHALL sustain one response per cycle when it is the only requester.
REQ-026 Responses per port SHALL be returned in request order.

Reset
REQ-027 While rst_n=0: req_ready=0, resp_valid=0, resp_data=0, resp_err=0, rom_addr=0, FIFOs empty, inflight=0, and the round-robin pointer favours port 0.
REQ-028 Reset asserted mid-transaction SHALL discard inflight reads; rom_data returned after reset release for a pre-reset grant SHALL NOT be written into any FIFO.

Structure
REQ-029 Package rom_arb_pkg SHALL hold NumPorts=2 and port index type port_idx_t; width-dependent types SHALL stay local to the module.
REQ-030 The per-port 2-entry FIFO SHALL be the sub-module rom_resp_fifo2 (parameter DataWidth), instantiated twice.

Verification
Bench setup: Width=32, Depth=32, rom[a] = 0xA000_0000 + a.

REQ-031 Port 0 only, addresses 3, 4, 5 back-to-back, resp_ready=1 -> resp_data[0] is 0xA0000003, 0xA0000004, 0xA0000005 on consecutive cycles, 1-cycle latency, err=0.
REQ-032 Both ports valid continuously (port 0 address 1, port 1 address 2) -> grants alternate 0,1,0,1 starting with port 0 after reset; each port receives a response every 2 cycles.
REQ-033 Port 1 with resp_ready=0 and 4 requests -> exactly 2 accepted, then req_ready[1]=0; port 0 continues to be granted; releasing resp_ready delivers data in order.
REQ-034 Depth=20, request to address 25 -> resp_data=0, resp_err=1; next request to address 7 -> 0xA0000007, err=0.
REQ-035 Assert rst_n low one cycle after a grant -> all outputs 0; after release, no stale response appears and the first grant goes to port 0.
REQ-036 Push and pop on a port in the same cycle with FIFO count=1 -> count stays 1 and output order is preserved.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared constants and port index type for the two-port ROM arbiter
package rom_arb_pkg;
  localparam int NumPorts = 2;
  typedef logic [$clog2(NumPorts)-1:0] port_idx_t;
endpackage

// File: rtl/rom_resp_fifo2.sv
// rtl/rom_resp_fifo2.sv - two-entry response FIFO; head is forced to zero while empty
module rom_resp_fifo2 #(
  parameter int DataWidth = 33
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DataWidth-1:0] push_data,
  input  logic                 pop,
  output logic [1:0]           count,
  output logic                 head_valid,
  output logic [DataWidth-1:0] head_data
);
  logic [DataWidth-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic                 pop_ok;

  assign head_valid = (count != 2'd0);
  assign pop_ok     = pop & head_valid;
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // The arbiter's eligibility rule guarantees push never lands on a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop_ok);
    end
  end
endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin sharing of one synchronous ROM read port between two requesters
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter  int Width     = 32,
  parameter  int Depth     = 32,
  localparam int AddrWidth = $clog2(Depth)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    req_valid,
  input  logic [1:0][AddrWidth-1:0]     req_addr,
  output logic [1:0]                    req_ready,
  output logic [1:0]                    resp_valid,
  output logic [1:0][Width-1:0]         resp_data,
  output logic [1:0]                    resp_err,
  input  logic [1:0]                    resp_ready,
  output logic [AddrWidth-1:0]          rom_addr,
  input  logic [Width-1:0]              rom_data
);
  localparam logic [AddrWidth:0] DepthW = (AddrWidth+1)'(Depth);

  logic [NumPorts-1:0] inflight;
  logic [NumPorts-1:0] eligible;
  logic [NumPorts-1:0] cand;
  logic [NumPorts-1:0] grant;
  logic [NumPorts-1:0] pop;
  logic [1:0]          count [NumPorts];
  logic [Width:0]      head  [NumPorts];
  port_idx_t           rr_ptr;
  port_idx_t           gnt_idx;
  logic                last_err;

  always_comb begin
    pop      = '0;
    eligible = '0;
    grant    = '0;
    gnt_idx  = '0;
    for (int i = 0; i < NumPorts; i++) begin
      pop[i]      = resp_valid[i] & resp_ready[i];
      eligible[i] = ({1'b0, count[i]} + {2'b00, inflight[i]}) < (3'd2 + {2'b00, pop[i]});
    end
    // Grants are suppressed during reset so nothing is launched toward the ROM.
    cand = req_valid & eligible & {NumPorts{rst_n}};
    if (cand[0] && cand[1]) begin
      gnt_idx = rr_ptr;
    end else if (cand[1]) begin
      gnt_idx = port_idx_t'(1);
    end
    if (|cand) begin
      grant[gnt_idx] = 1'b1;
    end
    rom_addr  = (|cand) ? req_addr[gnt_idx] : '0;
    req_ready = grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      inflight <= '0;
      last_err <= 1'b0;
    end else begin
      inflight <= grant;
      last_err <= ({1'b0, rom_addr} >= DepthW);
      if (|grant) begin
        rr_ptr <= ~gnt_idx;
      end
    end
  end

  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    rom_resp_fifo2 #(.DataWidth(Width + 1)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (inflight[i]),
      .push_data  ({last_err, rom_data}),
      .pop        (pop[i]),
      .count      (count[i]),
      .head_valid (resp_valid[i]),
      .head_data  (head[i])
    );
    assign resp_err[i]  = head[i][Width];
    assign resp_data[i] = head[i][Width-1:0];
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed bench for rom_arbiter (Depth=32 main instance, Depth=20 range instance)
module tb_rom_arbiter;
  localparam int W  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           req_valid, req_ready, resp_valid, resp_err, resp_ready;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][W-1:0]    resp_data;
  logic [AW-1:0]        rom_addr;
  logic [W-1:0]         rom_data;

  logic [1:0]           b_req_valid, b_req_ready, b_resp_valid, b_resp_err, b_resp_ready;
  logic [1:0][AW-1:0]   b_req_addr;
  logic [1:0][W-1:0]    b_resp_data;
  logic [AW-1:0]        b_rom_addr;
  logic [W-1:0]         b_rom_data;

  int n_checks = 0;
  int n_fail   = 0;

  rom_arbiter #(.Width(W), .Depth(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .resp_ready(resp_ready), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  rom_arbiter #(.Width(W), .Depth(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_addr(b_req_addr),
    .req_ready(b_req_ready), .resp_valid(b_resp_valid), .resp_data(b_resp_data),
    .resp_err(b_resp_err), .resp_ready(b_resp_ready), .rom_addr(b_rom_addr), .rom_data(b_rom_data)
  );

  always @(posedge clk) rom_data   <= (rom_addr < 32)   ? 32'hA000_0000 + 32'(rom_addr)   : '0;
  always @(posedge clk) b_rom_data <= (b_rom_addr < 20) ? 32'hA000_0000 + 32'(b_rom_addr) : '0;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; resp_ready = '0;
    b_req_valid = '0; b_req_addr = '0; b_resp_ready = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b11; req_addr[0] = 5'd5; req_addr[1] = 5'd6; resp_ready = 2'b11;
    b_req_valid = 2'b01; b_req_addr[0] = 5'd3;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready c%0d got=%b exp=00", c, req_ready); end
      n_checks++; if (rom_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rom_addr c%0d got=%0d exp=0", c, rom_addr); end
      n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid c%0d got=%b exp=00", c, resp_valid); end
      n_checks++; if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data c%0d got=%h exp=0", c, resp_data); end
      n_checks++; if (resp_err !== 2'b00) begin n_fail++; $display("FAIL reset_resp_err c%0d got=%b exp=00", c, resp_err); end
      n_checks++; if (b_req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_b_ready c%0d got=%b exp=00", c, b_req_ready); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_port();
    logic [1:0]  er [6] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [4:0]  ea [6] = '{5'd3, 5'd4, 5'd5, 5'd0, 5'd0, 5'd0};
    logic        ev [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ed [6] = '{32'h0, 32'h0, 32'hA000_0003, 32'hA000_0004, 32'hA000_0005, 32'h0};
    do_reset();
    resp_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      req_valid   = (c < 3) ? 2'b01 : 2'b00;
      req_addr[0] = AW'(3 + c);
      #1;
      n_checks++; if (req_ready !== er[c]) begin n_fail++; $display("FAIL single_ready c%0d got=%b exp=%b", c, req_ready, er[c]); end
      n_checks++; if (rom_addr !== ea[c]) begin n_fail++; $display("FAIL single_rom_addr c%0d got=%0d exp=%0d", c, rom_addr, ea[c]); end
      n_checks++; if (resp_valid[0] !== ev[c]) begin n_fail++; $display("FAIL single_valid c%0d got=%b exp=%b", c, resp_valid[0], ev[c]); end
      n_checks++; if (resp_data[0] !== ed[c]) begin n_fail++; $display("FAIL single_data c%0d got=%h exp=%h", c, resp_data[0], ed[c]); end
      n_checks++; if (resp_err[0] !== 1'b0) begin n_fail++; $display("FAIL single_err c%0d got=%b exp=0", c, resp_err[0]); end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] er [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [4:0] ea [6] = '{5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd2};
    logic [1:0] ev [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    resp_ready = 2'b11; req_valid = 2'b11; req_addr[0] = 5'd1; req_addr[1] = 5'd2;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++; if (req_ready !== er[c]) begin n_fail++; $display("FAIL rr_ready c%0d got=%b exp=%b", c, req_ready, er[c]); end
      n_checks++; if (rom_addr !== ea[c]) begin n_fail++; $display("FAIL rr_rom_addr c%0d got=%0d exp=%0d", c, rom_addr, ea[c]); end
      n_checks++; if (resp_valid !== ev[c]) begin n_fail++; $display("FAIL rr_valid c%0d got=%b exp=%b", c, resp_valid, ev[c]); end
      if (ev[c][0]) begin
        n_checks++; if (resp_data[0] !== 32'hA000_0001) begin n_fail++; $display("FAIL rr_data0 c%0d got=%h exp=a0000001", c, resp_data[0]); end
      end
      if (ev[c][1]) begin
        n_checks++; if (resp_data[1] !== 32'hA000_0002) begin n_fail++; $display("FAIL rr_data1 c%0d got=%h exp=a0000002", c, resp_data[1]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] er [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};
    logic [4:0] ea [6] = '{5'd20, 5'd10, 5'd20, 5'd11, 5'd20, 5'd20};
    int acc1 = 0;
    do_reset();
    resp_ready = 2'b01; req_valid = 2'b11; req_addr[0] = 5'd20;
    for (int c = 0; c < 6; c++) begin
      req_addr[1] = AW'(10 + acc1);
      #1;
      n_checks++; if (req_ready !== er[c]) begin n_fail++; $display("FAIL bp_ready c%0d got=%b exp=%b", c, req_ready, er[c]); end
      n_checks++; if (rom_addr !== ea[c]) begin n_fail++; $display("FAIL bp_rom_addr c%0d got=%0d exp=%0d", c, rom_addr, ea[c]); end
      if (req_ready[1]) acc1++;
      @(negedge clk);
    end
    n_checks++; if (acc1 !== 2) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=2", acc1); end
    #1;
    n_checks++; if (resp_valid[1] !== 1'b1 || resp_data[1] !== 32'hA000_000A) begin n_fail++; $display("FAIL bp_hold got=%b/%h exp=1/a000000a", resp_valid[1], resp_data[1]); end
    req_valid = 2'b00; resp_ready = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready_idle got=%b exp=00", req_ready); end
    @(negedge clk); #1;
    n_checks++; if (resp_valid[1] !== 1'b1 || resp_data[1] !== 32'hA000_000B) begin n_fail++; $display("FAIL bp_drain2 got=%b/%h exp=1/a000000b", resp_valid[1], resp_data[1]); end
    @(negedge clk); #1;
    n_checks++; if (resp_valid[1] !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b exp=0", resp_valid[1]); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    b_resp_ready = 2'b01; b_req_valid = 2'b01; b_req_addr[0] = 5'd25;
    #1;
    n_checks++; if (b_req_ready !== 2'b01 || b_rom_addr !== 5'd25) begin n_fail++; $display("FAIL oor_grant got=%b/%0d exp=01/25", b_req_ready, b_rom_addr); end
    @(negedge clk);
    b_req_addr[0] = 5'd7;
    @(negedge clk);
    b_req_valid = 2'b00;
    #1;
    n_checks++; if (b_resp_valid[0] !== 1'b1 || b_resp_data[0] !== 32'h0 || b_resp_err[0] !== 1'b1) begin n_fail++; $display("FAIL oor_err_resp got=%b/%h/%b exp=1/00000000/1", b_resp_valid[0], b_resp_data[0], b_resp_err[0]); end
    @(negedge clk); #1;
    n_checks++; if (b_resp_valid[0] !== 1'b1 || b_resp_data[0] !== 32'hA000_0007 || b_resp_err[0] !== 1'b0) begin n_fail++; $display("FAIL oor_ok_resp got=%b/%h/%b exp=1/a0000007/0", b_resp_valid[0], b_resp_data[0], b_resp_err[0]); end
    @(negedge clk); #1;
    n_checks++; if (b_resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL oor_empty got=%b exp=0", b_resp_valid[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    resp_ready = 2'b11; req_valid = 2'b11; req_addr[0] = 5'd5; req_addr[1] = 5'd6;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant got=%b exp=01", req_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (req_ready !== 2'b00 || rom_addr !== 5'd0) begin n_fail++; $display("FAIL mid_reset_req got=%b/%0d exp=00/0", req_ready, rom_addr); end
    n_checks++; if (resp_valid !== 2'b00 || resp_data !== '0 || resp_err !== 2'b00) begin n_fail++; $display("FAIL mid_reset_resp got=%b/%h/%b exp=00/0/00", resp_valid, resp_data, resp_err); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_stale c%0d got=%b exp=00", c, resp_valid); end
      @(negedge clk);
    end
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01 || rom_addr !== 5'd5) begin n_fail++; $display("FAIL mid_post_grant got=%b/%0d exp=01/5", req_ready, rom_addr); end
  endtask

  task automatic test_push_pop();
    do_reset();
    resp_ready = 2'b00; req_valid = 2'b01; req_addr[0] = 5'd8;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    req_valid = 2'b01; req_addr[0] = 5'd9;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL pp_second_grant got=%b exp=01", req_ready); end
    n_checks++; if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'hA000_0008) begin n_fail++; $display("FAIL pp_head1 got=%b/%h exp=1/a0000008", resp_valid[0], resp_data[0]); end
    @(negedge clk);
    req_valid = 2'b00; resp_ready = 2'b01;
    #1;
    n_checks++; if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'hA000_0008) begin n_fail++; $display("FAIL pp_head_before got=%b/%h exp=1/a0000008", resp_valid[0], resp_data[0]); end
    @(negedge clk);
    resp_ready = 2'b00;
    #1;
    n_checks++; if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'hA000_0009) begin n_fail++; $display("FAIL pp_head_after got=%b/%h exp=1/a0000009", resp_valid[0], resp_data[0]); end
    @(negedge clk); #1;
    n_checks++; if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'hA000_0009) begin n_fail++; $display("FAIL pp_held got=%b/%h exp=1/a0000009", resp_valid[0], resp_data[0]); end
    resp_ready = 2'b01;
    @(negedge clk); #1;
    n_checks++; if (resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL pp_count_one got=%b exp=0", resp_valid[0]); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; resp_ready = '0;
    b_req_valid = '0; b_req_addr = '0; b_resp_ready = '0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
